// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised synchronous RAM with byte-enabled writes and 1-cycle reads on a shared bus.
// Optional power-up clear sweep enabled by defining DMEM_INIT_CLEAR_EN.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_wen,
  input  logic [3:0]  byte_en,
  input  logic [31:0] dmem_addr,
  inout  logic [31:0] dmem_data,
  output logic        ready,
  output logic        rd_valid,
  output logic        err_oob
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);

`ifdef DMEM_INIT_CLEAR_EN
  localparam logic [1:0]    ST_INIT  = 2'd0;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
`endif
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [31:0]   rd_data_q;
  logic          drive_q;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          req;
  logic          wr_req;
  logic          rd_req;
  logic          wr_hit;
  logic          unused_offset_bits;

  // Address decode: a wrapped subtraction catches addresses below the base via the explicit compare.
  assign offset             = dmem_addr - BASE_ADDR;
  assign in_range           = (dmem_addr >= BASE_ADDR) && ({2'b00, offset[31:2]} < DEPTH_W);
  assign idx                = offset[AW+1:2];
  assign unused_offset_bits = ^offset[1:0];

`ifdef DMEM_INIT_CLEAR_EN
  logic [AW-1:0] clr_cnt;
  logic          clr_we;

  assign ready  = (state != ST_INIT);
  assign clr_we = (state == ST_INIT) & ~rst;
`else
  assign ready  = 1'b1;
`endif

  assign req    = ready & |byte_en;
  assign wr_req = req & dmem_wen;
  assign rd_req = req & ~dmem_wen;
  // A request coinciding with rst is swallowed so reset always dominates.
  assign wr_hit = wr_req & in_range & ~rst;

  // Bus ownership: the CPU raising dmem_wen releases the bus immediately, even mid data cycle.
  assign drive_q   = (state == ST_RD);
  assign rd_valid  = drive_q & ~dmem_wen;
  assign dmem_data = rd_valid ? rd_data_q : 32'bz;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
`ifdef DMEM_INIT_CLEAR_EN
      ST_INIT: if (clr_cnt == LAST_IDX) next_state = ST_IDLE;
`endif
      ST_IDLE,
      ST_RD:   next_state = rd_req ? ST_RD : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_INIT_CLEAR_EN
      state   <= ST_INIT;
      clr_cnt <= '0;
`else
      state   <= ST_IDLE;
`endif
      rd_data_q <= '0;
      err_oob   <= 1'b0;
    end else begin
      state <= next_state;
      if (rd_req) rd_data_q <= in_range ? mem[idx] : 32'h0;
      if ((rd_req | wr_req) && !in_range) err_oob <= 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
      if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
`endif
    end
  end

  // NOTE: the RAM array is never reset so it maps onto block RAM; only the optional sweep clears it.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= dmem_data[8*i +: 8];
      end
    end
`ifdef DMEM_INIT_CLEAR_EN
    if (clr_we) mem[clr_cnt] <= 32'h0;
`endif
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus scoreboard queue of expected read words.
// Define DMEM_INIT_CLEAR_EN for both RTL and bench to exercise the clear sweep.
module tb_dmem_responder;

  localparam int          DEPTH    = 16;
  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] OOB_ADDR = BASE + 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_wen;
  logic [3:0]  byte_en;
  logic [31:0] dmem_addr;
  wire  [31:0] dmem_data;
  logic        ready;
  logic        rd_valid;
  logic        err_oob;

  logic        tb_drive;
  logic [31:0] tb_wdata;

  assign dmem_data = tb_drive ? tb_wdata : 32'bz;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .dmem_wen  (dmem_wen),
    .byte_en   (byte_en),
    .dmem_addr (dmem_addr),
    .dmem_data (dmem_data),
    .ready     (ready),
    .rd_valid  (rd_valid),
    .err_oob   (err_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  logic [31:0] sb [$];
  logic        err_exp = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check outputs of this cycle, then model the coming edge.
  task automatic step(input logic r, input logic wen, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [31:0] exp_d;
    logic        exp_v;
    logic        oob;
    @(negedge clk);
    rst = r; dmem_wen = wen; byte_en = be; dmem_addr = addr;
    tb_drive = wen; tb_wdata = wd;
    #1;
    exp_v = 1'b0;
    exp_d = 32'h0;
    if (sb.size() > 0) begin
      exp_d = sb.pop_front();
      exp_v = ~wen;
    end
    check("ready", {31'b0, ready}, 32'd1);
    check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_v});
    if (exp_v) check("rd_data", dmem_data, exp_d);
    if (wen) check("wr_bus_released", dmem_data, wd);
    check("err_oob", {31'b0, err_oob}, {31'b0, err_exp});
    if (r) begin
      sb.delete();
      err_exp = 1'b0;
    end else if (be != 4'h0) begin
      oob = (addr < BASE) || (addr >= OOB_ADDR);
      if (oob) err_exp = 1'b1;
      if (!wen) sb.push_back(oob ? 32'h0 : exp_rd);
    end
  endtask

`ifdef DMEM_INIT_CLEAR_EN
  // Caller has just released rst at a negedge; an out-of-range read is held to prove INIT ignores it.
  task automatic sweep_check(input string name);
    int n;
    n = 0;
    dmem_wen = 1'b0; byte_en = 4'hF; dmem_addr = OOB_ADDR; tb_drive = 1'b0;
    #1;
    check({name, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
    while (ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    byte_en = 4'h0;
    check(name, n, 32'd16);
    check({name, "_err_oob"}, {31'b0, err_oob}, 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 4'hF,    BASE + 32'h08, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 4'hF,    BASE + 32'h08, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 4'h0,    BASE,          32'h0,         32'h0};
    tbl[3]  = '{1'b1, 4'hF,    BASE + 32'h0C, 32'h1122_3344, 32'h0};
    tbl[4]  = '{1'b1, 4'b0100, BASE + 32'h0C, 32'h00AA_0000, 32'h0};
    tbl[5]  = '{1'b0, 4'b0001, BASE + 32'h0E, 32'h0,         32'h11AA_3344};
    tbl[6]  = '{1'b0, 4'h0,    BASE,          32'h0,         32'h0};
    tbl[7]  = '{1'b1, 4'hF,    BASE + 32'h00, 32'hA0A0_A0A0, 32'h0};
    tbl[8]  = '{1'b1, 4'hF,    BASE + 32'h04, 32'hB1B1_B1B1, 32'h0};
    tbl[9]  = '{1'b1, 4'b0011, BASE + 32'h04, 32'h0000_5555, 32'h0};
    tbl[10] = '{1'b0, 4'hF,    BASE + 32'h00, 32'h0,         32'hA0A0_A0A0};
    tbl[11] = '{1'b0, 4'hF,    BASE + 32'h04, 32'h0,         32'hB1B1_5555};
    tbl[12] = '{1'b0, 4'hF,    BASE + 32'h08, 32'h0,         32'hDEAD_BEEF};
    tbl[13] = '{1'b1, 4'hF,    BASE + 32'h08, 32'hCAFE_F00D, 32'h0};
    tbl[14] = '{1'b0, 4'hF,    BASE + 32'h08, 32'h0,         32'hCAFE_F00D};
    tbl[15] = '{1'b0, 4'h0,    BASE,          32'h0,         32'h0};
    tbl[16] = '{1'b1, 4'hF,    BASE + 32'h3C, 32'h1234_5678, 32'h0};
    tbl[17] = '{1'b0, 4'hF,    BASE + 32'h3C, 32'h0,         32'h1234_5678};
    tbl[18] = '{1'b0, 4'hF,    OOB_ADDR,      32'h0,         32'h0};
    tbl[19] = '{1'b0, 4'hF,    BASE + 32'h00, 32'h0,         32'hA0A0_A0A0};
    tbl[20] = '{1'b0, 4'h0,    BASE,          32'h0,         32'h0};
    tbl[21] = '{1'b1, 4'hF,    OOB_ADDR,      32'h5555_5555, 32'h0};
    tbl[22] = '{1'b0, 4'hF,    BASE - 32'h4,  32'h0,         32'h0};
    tbl[23] = '{1'b0, 4'hF,    BASE + 32'h00, 32'h0,         32'hA0A0_A0A0};
    tbl[24] = '{1'b0, 4'h0,    BASE,          32'h0,         32'h0};

    rst = 1'b1; dmem_wen = 1'b0; byte_en = 4'h0; dmem_addr = BASE;
    tb_drive = 1'b0; tb_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("reset_err_oob", {31'b0, err_oob}, 32'd0);
`ifdef DMEM_INIT_CLEAR_EN
    check("reset_ready", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep_check("init_len");

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sweep_check("restart_len");

    for (int w = 0; w < DEPTH; w++) step(1'b0, 1'b0, 4'hF, BASE + 32'(4 * w), 32'h0, 32'h0);
    step(1'b0, 1'b0, 4'h0, BASE, 32'h0, 32'h0);
`else
    check("reset_ready", {31'b0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
`endif

    for (int i = 0; i < NVEC; i++)
      step(1'b0, tbl[i].wen, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);

    // Reset asserted during the data cycle of a read.
    step(1'b0, 1'b0, 4'hF, BASE, 32'h0, 32'hA0A0_A0A0);
    step(1'b1, 1'b0, 4'h0, BASE, 32'h0, 32'h0);
`ifdef DMEM_INIT_CLEAR_EN
    @(negedge clk);
    rst = 1'b0;
    sweep_check("rst_mid_read_sweep");
    step(1'b0, 1'b0, 4'hF, BASE, 32'h0, 32'h0);
`else
    step(1'b0, 1'b0, 4'hF, BASE, 32'h0, 32'hA0A0_A0A0);
`endif
    step(1'b0, 1'b0, 4'h0, BASE, 32'h0, 32'h0);
    step(1'b0, 1'b0, 4'h0, BASE, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
